// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: NOP encoding, memory-stage FSM states, M-W register layout.
package simplerisc_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] ld_result;
        logic [31:0] instruction;
        logic        is_ld;
        logic        is_wb;
        logic        is_call;
        logic [3:0]  rd;
        logic [3:0]  ra;
    } mw_reg_t;

    // A bubble is a NOP with every other field cleared; also the M-W reset value.
    function automatic mw_reg_t mw_bubble();
        mw_reg_t b;
        b             = '0;
        b.instruction = NOP_INSTR;
        return b;
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory request/ready bus between the memory stage (master) and the data memory (slave).
interface memory_access_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );

endinterface

// File: rtl/mem_handshake_fsm.sv
// IDLE/WAIT handshake controller for the memory stage; optional watchdog under MEM_TIMEOUT_EN.
module mem_handshake_fsm
    import simplerisc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_op,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic mem_stall,
    output logic capture,
    output logic abort
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_WAIT = WAIT;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       timeout_hit;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q;

    assign timeout_hit = (state_q == S_WAIT) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Counts completed WAIT cycles of the current access; cleared whenever we head back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else if (state_d == S_IDLE) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output is given a default first so no branch of the case can infer a latch.
        state_d   = state_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;

        case (state_q)
            S_IDLE: begin
                dmem_req = mem_op;
                if (!mem_op || dmem_ready) begin
                    capture = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset silences the bus and releases upstream even if reset lands mid-access.
        if (rst) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
            capture   = 1'b0;
            abort     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// SimpleRISC M stage: data-memory access with ready handshake, upstream stall, M-W register.
// Optional watchdog abort and sticky mem_fault enabled by defining MEM_TIMEOUT_EN.
module memory_access_stage
    import simplerisc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           pc_M,
    input  logic [31:0]           alu_result_M,
    input  logic [31:0]           rd2_M,
    input  logic [31:0]           instruction_M,
    input  logic                  isLd_M,
    input  logic                  isSt_M,
    input  logic                  isWb_M,
    input  logic                  isCall_M,
    input  logic [3:0]            RD_M,
    input  logic [3:0]            ra_M,

    memory_access_stage_if.master dmem,

    output logic                  mem_stall,
    output logic [31:0]           data_M_E,
    output logic [31:0]           memory_unit_data,

    output logic [31:0]           pc_W,
    output logic [31:0]           alu_result_W,
    output logic [31:0]           ld_result_W,
    output logic [31:0]           instruction_W,
    output logic                  isLd_W,
    output logic                  isWb_W,
    output logic                  isCall_W,
    output logic [3:0]            RD_W,
    output logic [3:0]            ra_W,

    output logic                  mem_fault
);

    logic    mem_op;
    logic    req;
    logic    capture;
    logic    abort;
    mw_reg_t mw_q;

    assign mem_op = isLd_M | isSt_M;

    mem_handshake_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_op     (mem_op),
        .dmem_ready (dmem.dmem_ready),
        .dmem_req   (req),
        .mem_stall  (mem_stall),
        .capture    (capture),
        .abort      (abort)
    );

    // Address, direction and data are only driven while a request is outstanding.
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & isSt_M;
    assign dmem.dmem_addr  = req ? alu_result_M : '0;
    assign dmem.dmem_wdata = req ? rd2_M        : '0;

    assign data_M_E = alu_result_M;

    always_ff @(posedge clk) begin
        if (rst || abort || !capture) begin
            mw_q <= mw_bubble();
        end else begin
            mw_q <= '{
                pc:          pc_M,
                alu_result:  alu_result_M,
                ld_result:   isLd_M ? dmem.dmem_rdata : 32'h0,
                instruction: instruction_M,
                is_ld:       isLd_M,
                is_wb:       isWb_M,
                is_call:     isCall_M,
                rd:          RD_M,
                ra:          ra_M
            };
        end
    end

    assign pc_W             = mw_q.pc;
    assign alu_result_W     = mw_q.alu_result;
    assign ld_result_W      = mw_q.ld_result;
    assign instruction_W    = mw_q.instruction;
    assign isLd_W           = mw_q.is_ld;
    assign isWb_W           = mw_q.is_wb;
    assign isCall_W         = mw_q.is_call;
    assign RD_W             = mw_q.rd;
    assign ra_W             = mw_q.ra;
    assign memory_unit_data = mw_q.ld_result;

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_fault <= 1'b0;
        end else if (abort) begin
            mem_fault <= 1'b1;
        end
    end
`else
    assign mem_fault = 1'b0;
`endif

endmodule
